wb_slave_decoder: RTL and testbench

- Wishbone address decoder and single-transaction sequencer.
- Sits between the processor-side Wishbone master and a bank of software-register slaves: write registers (each with a 64 KB window, e.g. base 0x00000000, high 0x0000FFFF) and read registers.
- Routes one master cycle to exactly one slave and returns its data/ack/err.
- Generates err for unmapped addresses and for slaves that never acknowledge.

---
 rtl/wb_slave_decoder_pkg.sv | 27 ++
 rtl/wb_timeout_timer.sv | 30 +++
 rtl/wb_slave_decoder.sv | 234 +++++++++++++++++++++++
 tb/tb_wb_slave_decoder.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_slave_decoder_pkg.sv
// Shared definitions for the Wishbone slave decoder.
//   - wb_state_e : sequencer state (IDLE / BUSY / RESP)
//   - WB_DAT_W, WB_ADR_W, WB_SEL_W : Wishbone bus widths
//   - clog2()    : ceiling log2, used to size the slave index
package wb_slave_decoder_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_ADR_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_timeout_timer.sv
// Watchdog counter for the decoder's BUSY phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : increment the count by one
//   expired    : count has reached TIMEOUT
module wb_timeout_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign expired = (count_q == 16'(TIMEOUT));

endmodule

// File: rtl/wb_slave_decoder.sv
// Wishbone address decoder and single-transaction sequencer.
//
// Routes one master cycle to exactly one slave window, returns that slave's
// data/ack/err, and errors on unmapped addresses or slaves that stay silent
// for longer than TIMEOUT cycles.
//
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i      master cycle, strobe, write enable
//   m_sel_i/m_adr_i/m_dat_i     master byte selects, byte address, write data
//   m_dat_o/m_ack_o/m_err_o     read data, ack and error back to the master
//   s_cyc_o/s_stb_o             one-hot slave cycle / strobe
//   s_we_o/s_sel_o/s_adr_o/s_dat_o  broadcast request fields (address unmodified)
//   s_dat_i/s_ack_i/s_err_i     slave k read data at [32k+31:32k], acks, errors
//   timeout_cnt_o               saturating count of timeout errors
//
// Handshake: a request is accepted in IDLE when m_cyc_i & m_stb_i are high.
// The selected slave's strobe then stays high until it acks/errs, the timer
// expires or the master drops m_cyc_i. m_ack_o/m_err_o are high for exactly
// one cycle; the master must drop m_stb_i on seeing them, and the decoder
// samples a new request no earlier than the edge after the response clears.
//
// Build option: define WB_SLAVE_DECODER_STATS_EN to enable timeout_cnt_o;
// otherwise it is tied to zero.
//
// Debug: the sequencer state is held in state_q (wb_state_e).
module wb_slave_decoder
  import wb_slave_decoder_pkg::*;
#(
  parameter int                  NUM_SLAVES      = 4,
  parameter int                  SLAVE_ADDR_BITS = 16,
  parameter logic [WB_ADR_W-1:0] BASE_ADDR       = 32'h0000_0000,
  parameter int                  TIMEOUT         = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_n_i,
  input  logic                           m_cyc_i,
  input  logic                           m_stb_i,
  input  logic                           m_we_i,
  input  logic [WB_SEL_W-1:0]            m_sel_i,
  input  logic [WB_ADR_W-1:0]            m_adr_i,
  input  logic [WB_DAT_W-1:0]            m_dat_i,
  output logic [WB_DAT_W-1:0]            m_dat_o,
  output logic                           m_ack_o,
  output logic                           m_err_o,
  output logic [NUM_SLAVES-1:0]          s_cyc_o,
  output logic [NUM_SLAVES-1:0]          s_stb_o,
  output logic                           s_we_o,
  output logic [WB_SEL_W-1:0]            s_sel_o,
  output logic [WB_ADR_W-1:0]            s_adr_o,
  output logic [WB_DAT_W-1:0]            s_dat_o,
  input  logic [WB_DAT_W*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]          s_ack_i,
  input  logic [NUM_SLAVES-1:0]          s_err_i,
  output logic [15:0]                    timeout_cnt_o
);

  localparam int IDX_W = clog2(NUM_SLAVES);
  // Total decoded span; 33 bits so an address below BASE_ADDR shows up as a
  // huge offset instead of wrapping into the window.
  localparam logic [WB_ADR_W:0] SPAN = 33'(NUM_SLAVES) << SLAVE_ADDR_BITS;

  wb_state_e state_q, state_d;

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_SLAVES-1:0] strobe_q, strobe_d;
  logic [WB_DAT_W-1:0]   m_dat_d;
  logic                  m_ack_d, m_err_d;
  logic                  s_we_d;
  logic [WB_SEL_W-1:0]   s_sel_d;
  logic [WB_ADR_W-1:0]   s_adr_d;
  logic [WB_DAT_W-1:0]   s_dat_d;

  logic [WB_ADR_W:0]     offset;
  logic                  in_range;
  logic [IDX_W-1:0]      req_idx;

  logic                  sel_ack, sel_err;
  logic [WB_DAT_W-1:0]   sel_dat;

  logic                  timer_clr, timer_en, timer_expired;

  // Address decode of the incoming request.
  assign offset   = {1'b0, m_adr_i} - {1'b0, BASE_ADDR};
  assign in_range = (offset < SPAN);
  assign req_idx  = offset[SLAVE_ADDR_BITS +: IDX_W];

  // Responses from the slave latched at request time; others are ignored.
  assign sel_ack = s_ack_i[idx_q];
  assign sel_err = s_err_i[idx_q];

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) sel_dat = s_dat_i[k*WB_DAT_W +: WB_DAT_W];
    end
  end

  wb_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n_i),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    strobe_d  = strobe_q;
    m_dat_d   = m_dat_o;
    m_ack_d   = 1'b0;
    m_err_d   = 1'b0;
    s_we_d    = s_we_o;
    s_sel_d   = s_sel_o;
    s_adr_d   = s_adr_o;
    s_dat_d   = s_dat_o;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Holding the timer clear in IDLE guarantees it starts at zero in BUSY.
        timer_clr = 1'b1;
        if (m_cyc_i && m_stb_i) begin
          s_we_d  = m_we_i;
          s_sel_d = m_sel_i;
          s_adr_d = m_adr_i;
          s_dat_d = m_dat_i;
          if (in_range) begin
            idx_d             = req_idx;
            strobe_d          = '0;
            strobe_d[req_idx] = 1'b1;
            state_d           = ST_BUSY;
          end else begin
            m_err_d = 1'b1;
            m_dat_d = '0;
            state_d = ST_RESP;
          end
        end
      end

      ST_BUSY: begin
        // Slave err outranks a simultaneous ack; both outrank the timeout.
        if (!m_cyc_i) begin
          strobe_d = '0;
          state_d  = ST_IDLE;
        end else if (sel_err) begin
          m_err_d  = 1'b1;
          m_dat_d  = '0;
          strobe_d = '0;
          state_d  = ST_RESP;
        end else if (sel_ack) begin
          m_ack_d  = 1'b1;
          m_dat_d  = sel_dat;
          strobe_d = '0;
          state_d  = ST_RESP;
        end else if (timer_expired) begin
          m_err_d  = 1'b1;
          m_dat_d  = '0;
          strobe_d = '0;
          state_d  = ST_RESP;
        end else begin
          timer_en = 1'b1;
        end
      end

      ST_RESP: begin
        // ack/err default low here, so the response lasts one cycle.
        state_d = ST_IDLE;
      end

      default: begin
        strobe_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      strobe_q <= '0;
      m_dat_o  <= '0;
      m_ack_o  <= 1'b0;
      m_err_o  <= 1'b0;
      s_we_o   <= 1'b0;
      s_sel_o  <= '0;
      s_adr_o  <= '0;
      s_dat_o  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      m_dat_o  <= m_dat_d;
      m_ack_o  <= m_ack_d;
      m_err_o  <= m_err_d;
      s_we_o   <= s_we_d;
      s_sel_o  <= s_sel_d;
      s_adr_o  <= s_adr_d;
      s_dat_o  <= s_dat_d;
    end
  end

  // Cycle and strobe always move together for a single-beat classic cycle.
  assign s_cyc_o = strobe_q;
  assign s_stb_o = strobe_q;

`ifdef WB_SLAVE_DECODER_STATS_EN
  logic        timeout_evt;
  logic [15:0] timeout_cnt_q;

  // Mirrors the lowest-priority BUSY branch: only a genuine timeout counts.
  assign timeout_evt = (state_q == ST_BUSY) && m_cyc_i && !sel_err &&
                       !sel_ack && timer_expired;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      timeout_cnt_q <= '0;
    end else if (timeout_evt && (timeout_cnt_q != 16'hFFFF)) begin
      timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign timeout_cnt_o = timeout_cnt_q;
`else
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_slave_decoder.sv
module tb_wb_slave_decoder;

  localparam int NS = 4;

  logic          wb_clk_i;
  logic          wb_rst_n_i;
  logic          m_cyc_i, m_stb_i, m_we_i;
  logic [3:0]    m_sel_i;
  logic [31:0]   m_adr_i, m_dat_i;
  logic [31:0]   m_dat_o;
  logic          m_ack_o, m_err_o;
  logic [NS-1:0] s_cyc_o, s_stb_o;
  logic          s_we_o;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [32*NS-1:0] s_dat_i;
  logic [NS-1:0] s_ack_i, s_err_i;
  logic [15:0]   timeout_cnt_o;

  int n_checks;
  int n_errors;

`ifdef WB_SLAVE_DECODER_STATS_EN
  localparam logic [15:0] EXP_TO_CNT = 16'd1;
`else
  localparam logic [15:0] EXP_TO_CNT = 16'd0;
`endif

  wb_slave_decoder #(
    .NUM_SLAVES      (NS),
    .SLAVE_ADDR_BITS (16),
    .BASE_ADDR       (32'h0000_0000),
    .TIMEOUT         (8)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_n_i    (wb_rst_n_i),
    .m_cyc_i       (m_cyc_i),
    .m_stb_i       (m_stb_i),
    .m_we_i        (m_we_i),
    .m_sel_i       (m_sel_i),
    .m_adr_i       (m_adr_i),
    .m_dat_i       (m_dat_i),
    .m_dat_o       (m_dat_o),
    .m_ack_o       (m_ack_o),
    .m_err_o       (m_err_o),
    .s_cyc_o       (s_cyc_o),
    .s_stb_o       (s_stb_o),
    .s_we_o        (s_we_o),
    .s_sel_o       (s_sel_o),
    .s_adr_o       (s_adr_o),
    .s_dat_o       (s_dat_o),
    .s_dat_i       (s_dat_i),
    .s_ack_i       (s_ack_i),
    .s_err_i       (s_err_i),
    .timeout_cnt_o (timeout_cnt_o)
  );

  // Clock / reset block
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks. Inputs change and outputs are sampled 1 time unit after
  // each rising edge.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic start_cycle(input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i = 1'b1;
    m_stb_i = 1'b1;
    m_we_i  = we;
    m_sel_i = sel;
    m_adr_i = adr;
    m_dat_i = dat;
  endtask

  task automatic end_cycle();
    m_cyc_i = 1'b0;
    m_stb_i = 1'b0;
    m_we_i  = 1'b0;
    s_ack_i = '0;
    s_err_i = '0;
  endtask

  task automatic test_reset();
    wb_rst_n_i = 1'b0;
    end_cycle();
    m_sel_i = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    s_dat_i = '0;
    tick();
    tick();
    if ({m_ack_o, m_err_o} !== 2'b00) begin
      $display("FAIL reset_ack_err: got %b expected 00", {m_ack_o, m_err_o}); n_errors++;
    end
    n_checks++;
    if (m_dat_o !== 32'h0) begin
      $display("FAIL reset_m_dat: got %h expected 00000000", m_dat_o); n_errors++;
    end
    n_checks++;
    if ({s_cyc_o, s_stb_o} !== 8'h00) begin
      $display("FAIL reset_strobes: got %b expected 00000000", {s_cyc_o, s_stb_o}); n_errors++;
    end
    n_checks++;
    if ({s_we_o, s_sel_o, s_adr_o, s_dat_o} !== 69'h0) begin
      $display("FAIL reset_bcast: got %h expected 0", {s_we_o, s_sel_o, s_adr_o, s_dat_o}); n_errors++;
    end
    n_checks++;
    if (timeout_cnt_o !== 16'h0) begin
      $display("FAIL reset_to_cnt: got %h expected 0000", timeout_cnt_o); n_errors++;
    end
    n_checks++;
    #2 wb_rst_n_i = 1'b1;
    tick();
  endtask

  // Write to slave 0; slave acks one cycle after it sees its strobe, so the
  // decoder samples the ack at edge 2 and m_ack_o is high after edge 2.
  task automatic test_write();
    start_cycle(1'b1, 4'hE, 32'h0000_0000, 32'hEEEE_EEEE);
    tick(); // edge 0
    if (s_stb_o !== 4'b0001 || s_cyc_o !== 4'b0001) begin
      $display("FAIL wr_strobe: got stb %b cyc %b expected 0001", s_stb_o, s_cyc_o); n_errors++;
    end
    n_checks++;
    if (s_sel_o !== 4'hE || s_dat_o !== 32'hEEEE_EEEE || s_we_o !== 1'b1 || s_adr_o !== 32'h0) begin
      $display("FAIL wr_bcast: got sel %h dat %h we %b adr %h expected E EEEEEEEE 1 0",
               s_sel_o, s_dat_o, s_we_o, s_adr_o); n_errors++;
    end
    n_checks++;
    tick(); // edge 1
    if (m_ack_o !== 1'b0 || s_stb_o !== 4'b0001) begin
      $display("FAIL wr_wait: got ack %b stb %b expected 0 0001", m_ack_o, s_stb_o); n_errors++;
    end
    n_checks++;
    s_ack_i = 4'b0001;
    tick(); // edge 2
    if (m_ack_o !== 1'b1 || m_err_o !== 1'b0 || s_stb_o !== 4'b0000) begin
      $display("FAIL wr_ack: got ack %b err %b stb %b expected 1 0 0000", m_ack_o, m_err_o, s_stb_o); n_errors++;
    end
    n_checks++;
    end_cycle();
    tick(); // edge 3
    if (m_ack_o !== 1'b0) begin
      $display("FAIL wr_ack_one_cycle: got ack %b expected 0", m_ack_o); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_read();
    s_dat_i[0*32 +: 32] = 32'hDEAD_BEEF;
    s_dat_i[3*32 +: 32] = 32'h1234_5678;
    start_cycle(1'b0, 4'hF, 32'h0003_0004, 32'h0);
    tick();
    if (s_stb_o !== 4'b1000 || s_adr_o !== 32'h0003_0004 || s_we_o !== 1'b0) begin
      $display("FAIL rd_strobe: got stb %b adr %h we %b expected 1000 00030004 0",
               s_stb_o, s_adr_o, s_we_o); n_errors++;
    end
    n_checks++;
    s_ack_i = 4'b1000;
    tick();
    if (m_ack_o !== 1'b1 || m_dat_o !== 32'h1234_5678) begin
      $display("FAIL rd_data: got ack %b dat %h expected 1 12345678", m_ack_o, m_dat_o); n_errors++;
    end
    n_checks++;
    end_cycle();
    tick();
    if (m_ack_o !== 1'b0 || m_dat_o !== 32'h1234_5678) begin
      $display("FAIL rd_hold: got ack %b dat %h expected 0 12345678", m_ack_o, m_dat_o); n_errors++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_unmapped();
    // Last byte of the last window is still mapped.
    start_cycle(1'b0, 4'hF, 32'h0003_FFFF, 32'h0);
    tick();
    if (s_stb_o !== 4'b1000 || m_err_o !== 1'b0) begin
      $display("FAIL top_edge_map: got stb %b err %b expected 1000 0", s_stb_o, m_err_o); n_errors++;
    end
    n_checks++;
    s_ack_i = 4'b1000;
    tick();
    end_cycle();
    tick();
    tick();
    start_cycle(1'b1, 4'hF, 32'h0004_0000, 32'hAAAA_5555);
    tick();
    if (s_stb_o !== 4'b0000 || s_cyc_o !== 4'b0000) begin
      $display("FAIL unmapped_strobe: got stb %b cyc %b expected 0000", s_stb_o, s_cyc_o); n_errors++;
    end
    n_checks++;
    if (m_err_o !== 1'b1 || m_ack_o !== 1'b0 || m_dat_o !== 32'h0) begin
      $display("FAIL unmapped_err: got err %b ack %b dat %h expected 1 0 00000000",
               m_err_o, m_ack_o, m_dat_o); n_errors++;
    end
    n_checks++;
    end_cycle();
    tick();
    if (m_err_o !== 1'b0) begin
      $display("FAIL unmapped_err_pulse: got err %b expected 0", m_err_o); n_errors++;
    end
    n_checks++;
    tick();
  endtask

  // TIMEOUT=8: timer is 0 on entry to BUSY, so the error is sampled at
  // edge 9 counting from the request edge.
  task automatic test_timeout();
    start_cycle(1'b0, 4'hF, 32'h0001_0010, 32'h0);
    tick(); // edge 0
    if (s_stb_o !== 4'b0010) begin
      $display("FAIL to_strobe: got %b expected 0010", s_stb_o); n_errors++;
    end
    n_checks++;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (m_err_o !== 1'b0 || s_stb_o !== 4'b0010) begin
        $display("FAIL to_wait_%0d: got err %b stb %b expected 0 0010", i, m_err_o, s_stb_o); n_errors++;
      end
      n_checks++;
    end
    tick(); // edge 9
    if (m_err_o !== 1'b1 || m_ack_o !== 1'b0 || s_stb_o !== 4'b0000) begin
      $display("FAIL to_err: got err %b ack %b stb %b expected 1 0 0000", m_err_o, m_ack_o, s_stb_o); n_errors++;
    end
    n_checks++;
    if (timeout_cnt_o !== EXP_TO_CNT) begin
      $display("FAIL to_count: got %h expected %h", timeout_cnt_o, EXP_TO_CNT); n_errors++;
    end
    n_checks++;
    end_cycle();
    tick();
    if (m_err_o !== 1'b0) begin
      $display("FAIL to_err_pulse: got err %b expected 0", m_err_o); n_errors++;
    end
    n_checks++;
    tick();
  endtask

  task automatic test_ack_err();
    s_dat_i[2*32 +: 32] = 32'hCAFE_F00D;
    start_cycle(1'b0, 4'hF, 32'h0002_0000, 32'h0);
    tick();
    if (s_stb_o !== 4'b0100) begin
      $display("FAIL ae_strobe: got %b expected 0100", s_stb_o); n_errors++;
    end
    n_checks++;
    s_ack_i = 4'b0001; // spurious ack from a non-selected slave
    s_err_i = 4'b0010; // spurious err from a non-selected slave
    tick();
    if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_stb_o !== 4'b0100) begin
      $display("FAIL ae_spurious: got ack %b err %b stb %b expected 0 0 0100",
               m_ack_o, m_err_o, s_stb_o); n_errors++;
    end
    n_checks++;
    s_ack_i = 4'b0100;
    s_err_i = 4'b0100;
    tick();
    if (m_err_o !== 1'b1 || m_ack_o !== 1'b0 || m_dat_o !== 32'h0 || s_stb_o !== 4'b0000) begin
      $display("FAIL ae_err_wins: got err %b ack %b dat %h stb %b expected 1 0 00000000 0000",
               m_err_o, m_ack_o, m_dat_o, s_stb_o); n_errors++;
    end
    n_checks++;
    if (timeout_cnt_o !== EXP_TO_CNT) begin
      $display("FAIL ae_count: got %h expected %h", timeout_cnt_o, EXP_TO_CNT); n_errors++;
    end
    n_checks++;
    end_cycle();
    tick();
    tick();
  endtask

  task automatic test_abort();
    start_cycle(1'b1, 4'h3, 32'h0001_0000, 32'h0BAD_0BAD);
    tick();
    if (s_cyc_o !== 4'b0010) begin
      $display("FAIL ab_strobe: got %b expected 0010", s_cyc_o); n_errors++;
    end
    n_checks++;
    end_cycle();
    tick();
    if (s_cyc_o !== 4'b0000 || m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin
      $display("FAIL ab_drop: got cyc %b ack %b err %b expected 0000 0 0", s_cyc_o, m_ack_o, m_err_o); n_errors++;
    end
    n_checks++;
    tick();
    if (m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin
      $display("FAIL ab_no_resp: got ack %b err %b expected 0 0", m_ack_o, m_err_o); n_errors++;
    end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    start_cycle(1'b0, 4'hF, 32'h0002_0008, 32'h0);
    tick();
    if (s_cyc_o !== 4'b0100) begin
      $display("FAIL rm_strobe: got %b expected 0100", s_cyc_o); n_errors++;
    end
    n_checks++;
    #1 wb_rst_n_i = 1'b0;
    #1;
    if (s_cyc_o !== 4'b0000 || s_stb_o !== 4'b0000 || m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin
      $display("FAIL rm_clear: got cyc %b stb %b ack %b err %b expected 0000 0000 0 0",
               s_cyc_o, s_stb_o, m_ack_o, m_err_o); n_errors++;
    end
    n_checks++;
    if (timeout_cnt_o !== 16'h0) begin
      $display("FAIL rm_count: got %h expected 0000", timeout_cnt_o); n_errors++;
    end
    n_checks++;
    end_cycle();
    tick();
    #1 wb_rst_n_i = 1'b1;
    tick();
  endtask

  // Zero-wait transaction used after abort/reset to show recovery.
  task automatic test_recover(input logic [31:0] adr, input logic [3:0] onehot,
                              input int slave, input logic [31:0] rdata);
    s_dat_i[slave*32 +: 32] = rdata;
    start_cycle(1'b0, 4'hF, adr, 32'h0);
    tick();
    if (s_stb_o !== onehot) begin
      $display("FAIL rec_strobe: got %b expected %b", s_stb_o, onehot); n_errors++;
    end
    n_checks++;
    s_ack_i = onehot;
    tick();
    if (m_ack_o !== 1'b1 || m_err_o !== 1'b0 || m_dat_o !== rdata) begin
      $display("FAIL rec_ack: got ack %b err %b dat %h expected 1 0 %h", m_ack_o, m_err_o, m_dat_o, rdata); n_errors++;
    end
    n_checks++;
    end_cycle();
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_write();
    test_read();
    test_unmapped();
    test_timeout();
    test_ack_err();
    test_abort();
    test_recover(32'h0000_0100, 4'b0001, 0, 32'h0101_0202);
    test_reset_mid();
    test_recover(32'h0002_0040, 4'b0100, 2, 32'h5A5A_A5A5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
